cache_nway_lru: RTL and testbench
=================================

Name: cache_nway_lru

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement. It is the next generation of the fixed 2-way L1 and sits between the core-side request port and a backing level (L2 or memory) reached over a req/ready handshake. Lines are one data word. The block adds write support, dirty-line writeback, a variable-latency memory handshake and hit/miss statistics counters.

Parameters:
ADDR_WIDTH, 11, byte/word address width; the tag is ADDR_WIDTH-IDX_W bits.
DATA_WIDTH, 11, data word width.
NUM_SETS, 8, number of sets; power of 2, >=2; IDX_W = log2(NUM_SETS).
NUM_WAYS, 4, associativity; power of 2, >=2; AGE_W = log2(NUM_WAYS).
CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
addr  in  ADDR_WIDTH  request address; index = addr[IDX_W-1:0], tag = remaining upper bits.
read  in  1  read request, sampled only in IDLE.
write  in  1  write request, sampled only in IDLE; takes priority when read is also high.
wdata  in  DATA_WIDTH  write data.
busy  out  1  high in every state except IDLE.
resp_valid  out  1  one-cycle pulse when a request completes.
read_data  out  DATA_WIDTH  read result, valid with resp_valid and held until the next read response.
l1_hit  out  1  valid with resp_valid; 1 = hit.
miss  out  1  valid with resp_valid; 1 = miss.
mem_req  out  1  backing-level request; held until accepted.
mem_we  out  1  1 = writeback, 0 = fill read.
mem_addr  out  ADDR_WIDTH  backing-level address.
mem_wdata  out  DATA_WIDTH  writeback data.
mem_ready  in  1  backing level accepts/completes the request in this cycle; mem_rdata is valid in the same cycle.
mem_rdata  in  DATA_WIDTH  fill data.
hit_count  out  CNT_WIDTH  saturating count of hits.
miss_count  out  CNT_WIDTH  saturating count of misses.

Behaviour:
- Reset: all valid and dirty bits are cleared and ages are set to way index. State goes to IDLE. busy, resp_valid, l1_hit, miss, mem_req and mem_we are 0. read_data, mem_addr and mem_wdata are 0. Both counters are 0.
- Reset mid-operation: an outstanding mem transaction is abandoned (mem_req is low after the edge) and dirty data is lost by design.
- States:
  - IDLE: if write or read is high, latch addr, wdata and op, then go to LOOKUP. Otherwise stay.
  - LOOKUP: compare the tag against all valid ways of the set.
    - Hit: a read loads read_data from the way; a write stores wdata and sets dirty. Pulse resp_valid with l1_hit=1, update LRU, go to IDLE. Hit latency is 2 edges from the accepting edge.
    - Miss: select a victim. If the victim is valid and dirty, go to WB. Otherwise a read goes to FILL and a write goes to ALLOC.
  - WB: mem_req=1, mem_we=1, mem_addr = {victim tag, index}, mem_wdata = victim data. On mem_ready a read goes to FILL and a write goes to ALLOC.
  - FILL: mem_req=1, mem_we=0, mem_addr = latched addr. On mem_ready install the line (valid, clean, data = mem_rdata) and go to RESP.
  - ALLOC: a write miss installs wdata as a valid, dirty line with no fill read, then goes to RESP.
  - RESP: pulse resp_valid with miss=1 (read_data = installed data for reads), update LRU, go to IDLE.
- Victim selection: the lowest-index invalid way; if none is invalid, the way whose age is NUM_WAYS-1.
- LRU update: the accessed way gets age 0; every way with age less than the accessed way's old age increments. Ages always form a permutation of 0..NUM_WAYS-1.
- Requests arriving while busy=1 are ignored (not queued). mem_ready outside WB/FILL is ignored.
- Counters increment at the resp_valid cycle and saturate at all-ones.

Decomposition:
- Package cache_pkg: state enum (IDLE, LOOKUP, WB, FILL, ALLOC, RESP), and the IDX_W/AGE_W/TAG_W derivation functions.
- One sub-module, cache_lru_set_ctrl: per-set age storage, victim select and age update, parametrised by NUM_WAYS.

Test Plan:
- The bench memory returns mem_rdata = mem_addr after a programmable delay (default 1 cycle).
- 1. After reset, read 0x123 -> mem read at 0x123, then resp with read_data=0x123, miss=1. Re-read 0x123 -> l1_hit=1, resp_valid exactly 2 edges after acceptance, no mem_req.
- 2. Read 0x003, 0x00B, 0x013, 0x01B (all set 3), re-read 0x003, then read 0x023 -> 0x00B is evicted. Read 0x00B -> miss; read 0x003 -> hit.
- 3. Fill set 3 as in scenario 2, write 0x013 with 0x7FF (hit, no mem traffic), then read 0x023, 0x02B, 0x033, 0x03B -> when 0x013 is evicted, a writeback with mem_we=1, addr 0x013, wdata 0x7FF precedes the fill.
- 4. Write miss 0x345 with 0x055 -> no fill read, miss=1. Read 0x345 -> hit, read_data=0x055. With read=write=1 the request is treated as a write.
- 5. Set mem delay to 5 cycles: busy stays high, and a read pulsed during FILL is ignored. Assert rst during FILL -> mem_req=0 after the edge; a later read of 0x123 misses.
- 6. After scenarios 1-2 -> hit_count=3, miss_count=7. Force 2^CNT_WIDTH hits -> hit_count holds at 0xFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way LRU cache.
package cache_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWb,
        StFill,
        StAlloc,
        StResp
    } state_e;

    function automatic int unsigned idx_w(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned age_w(input int unsigned num_ways);
        return $clog2(num_ways);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_width,
                                          input int unsigned num_sets);
        return addr_width - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/cache_lru_set_ctrl.sv
// Per-set true-LRU bookkeeping: age storage, victim selection and age update.
// Ages within a set are always a permutation of 0..NUM_WAYS-1; 0 is most recent.
module cache_lru_set_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned NUM_WAYS = 4,
    localparam int unsigned IDX_W = idx_w(NUM_SETS),
    localparam int unsigned AGE_W = age_w(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    idx,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic                upd_en,
    input  logic [AGE_W-1:0]    upd_way,
    output logic [AGE_W-1:0]    victim
);

    logic [AGE_W-1:0] age_q [NUM_SETS][NUM_WAYS];
    logic             found;

    // Victim: lowest-index invalid way, otherwise the oldest way.
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid[w] && !found) begin
                victim = AGE_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[idx][w] == AGE_W'(NUM_WAYS - 1)) begin
                    victim = AGE_W'(w);
                end
            end
        end
    end

    // Age update: accessed way becomes 0, younger ways age by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else if (upd_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (AGE_W'(w) == upd_way) begin
                    age_q[idx][w] <= '0;
                end else if (age_q[idx][w] < age_q[idx][upd_way]) begin
                    age_q[idx][w] <= age_q[idx][w] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cache_nway_lru.sv
// N-way set-associative write-back, write-allocate cache with true-LRU replacement.
// One data word per line; backing level reached over a req/ready handshake.
module cache_nway_lru
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned NUM_SETS   = 8,
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  l1_hit,
    output logic                  miss,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int unsigned IDX_W = idx_w(NUM_SETS);
    localparam int unsigned AGE_W = age_w(NUM_WAYS);
    localparam int unsigned TAG_W = tag_w(ADDR_WIDTH, NUM_SETS);

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  is_wr_q;
    logic [AGE_W-1:0]      victim_q;

    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

    logic                  resp_valid_q, l1_hit_q, miss_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic [CNT_WIDTH-1:0]  hit_count_q, miss_count_q;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit;
    logic [AGE_W-1:0]      hit_way;
    logic [AGE_W-1:0]      victim;
    logic                  lru_upd;
    logic [AGE_W-1:0]      lru_way;
    logic                  wr_hit, fill_en, alloc_en;

    assign req_idx = addr_q[IDX_W-1:0];
    assign req_tag = addr_q[ADDR_WIDTH-1:IDX_W];

    // Tag compare across all valid ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    assign wr_hit   = (state_q == StLookup) && hit && is_wr_q;
    assign fill_en  = (state_q == StFill) && mem_ready;
    assign alloc_en = (state_q == StAlloc);
    assign lru_upd  = ((state_q == StLookup) && hit) || (state_q == StResp);
    assign lru_way  = (state_q == StResp) ? victim_q : hit_way;

    cache_lru_set_ctrl #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .clk     (clk),
        .rst     (rst),
        .idx     (req_idx),
        .valid   (valid_q[req_idx]),
        .upd_en  (lru_upd),
        .upd_way (lru_way),
        .victim  (victim)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (write || read) state_d = StLookup;
            end
            StLookup: begin
                if (hit) begin
                    state_d = StIdle;
                end else if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                    state_d = StWb;
                end else begin
                    state_d = is_wr_q ? StAlloc : StFill;
                end
            end
            StWb: begin
                if (mem_ready) state_d = is_wr_q ? StAlloc : StFill;
            end
            StFill: begin
                if (mem_ready) state_d = StResp;
            end
            StAlloc: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Backing-level interface, driven only while a transaction is outstanding.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == StWb) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_q[req_idx][victim_q], req_idx};
            mem_wdata = data_q[req_idx][victim_q];
        end else if (state_q == StFill) begin
            mem_req  = 1'b1;
            mem_addr = addr_q;
        end
    end

    // State register and request latch; victim is frozen at lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && (write || read)) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                is_wr_q <= write;
            end
            if (state_q == StLookup) victim_q <= victim;
        end
    end

    // Valid and dirty bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
        end else if (wr_hit) begin
            dirty_q[req_idx][hit_way] <= 1'b1;
        end else if (fill_en || alloc_en) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= alloc_en;
        end
    end

    // Line payload; meaningless while the valid bit is clear, so no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_hit) begin
                data_q[req_idx][hit_way] <= wdata_q;
            end else if (fill_en || alloc_en) begin
                tag_q[req_idx][victim_q]  <= req_tag;
                data_q[req_idx][victim_q] <= fill_en ? mem_rdata : wdata_q;
            end
        end
    end

    // Response pulse, read result and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            l1_hit_q     <= 1'b0;
            miss_q       <= 1'b0;
            read_data_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            l1_hit_q     <= 1'b0;
            miss_q       <= 1'b0;
            if ((state_q == StLookup) && hit) begin
                resp_valid_q <= 1'b1;
                l1_hit_q     <= 1'b1;
                if (!is_wr_q) read_data_q <= data_q[req_idx][hit_way];
                if (!(&hit_count_q)) hit_count_q <= hit_count_q + CNT_WIDTH'(1);
            end else if (state_q == StResp) begin
                resp_valid_q <= 1'b1;
                miss_q       <= 1'b1;
                if (!is_wr_q) read_data_q <= data_q[req_idx][victim_q];
                if (!(&miss_count_q)) miss_count_q <= miss_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign busy       = (state_q != StIdle);
    assign resp_valid = resp_valid_q;
    assign l1_hit     = l1_hit_q;
    assign miss       = miss_q;
    assign read_data  = read_data_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_nway_lru.sv
// Bench for cache_nway_lru: directed scenarios plus random traffic against an
// LRU-list reference model; the backing memory returns its address as data.
module tb_cache_nway_lru;

    localparam int AW    = 11;
    localparam int DW    = 11;
    localparam int NS    = 8;
    localparam int NW    = 4;
    localparam int IW    = 3;
    localparam int TW    = AW - IW;
    // Narrow counters keep the saturation run short.
    localparam int CW    = 10;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          busy, resp_valid, l1_hit, miss;
    logic [DW-1:0] read_data;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [CW-1:0] hit_count, miss_count;

    cache_nway_lru #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_SETS   (NS),
        .NUM_WAYS   (NW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .read       (read),
        .write      (write),
        .wdata      (wdata),
        .busy       (busy),
        .resp_valid (resp_valid),
        .read_data  (read_data),
        .l1_hit     (l1_hit),
        .miss       (miss),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Backing memory: completed transactions are logged for comparison.
    int            mem_delay = 1;
    int            wait_cnt  = 0;
    bit            req_seen  = 1'b0;
    logic          log_we [$];
    logic [AW-1:0] log_ma [$];
    logic [DW-1:0] log_wd [$];

    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (mem_req && !rst) begin
            req_seen = 1'b1;
            if (wait_cnt >= mem_delay) begin
                mem_ready = 1'b1;
                mem_rdata = mem_addr;
                log_we.push_back(mem_we);
                log_ma.push_back(mem_addr);
                log_wd.push_back(mem_wdata);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Reference model: each set is a recency list, position 0 most recent.
    int            m_cnt   [NS];
    logic [TW-1:0] m_tag   [NS][NW];
    logic [DW-1:0] m_data  [NS][NW];
    bit            m_dirty [NS][NW];
    int            m_hits, m_misses;
    logic [DW-1:0] m_rd;
    logic          exp_we [$];
    logic [AW-1:0] exp_ma [$];
    logic [DW-1:0] exp_wd [$];

    task automatic model_reset();
        for (int s = 0; s < NS; s++) m_cnt[s] = 0;
        m_hits   = 0;
        m_misses = 0;
        m_rd     = '0;
    endtask

    task automatic model_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                output bit hit);
        logic [IW-1:0] s;
        logic [TW-1:0] t;
        int            p;
        logic [TW-1:0] st;
        logic [DW-1:0] sd;
        bit            sdy;
        s = a[IW-1:0];
        t = a[AW-1:IW];
        p = -1;
        for (int k = 0; k < m_cnt[s]; k++) if (m_tag[s][k] == t) p = k;
        hit = (p >= 0);
        if (hit) begin
            st = m_tag[s][p]; sd = m_data[s][p]; sdy = m_dirty[s][p];
            for (int k = p; k > 0; k--) begin
                m_tag[s][k] = m_tag[s][k-1]; m_data[s][k] = m_data[s][k-1];
                m_dirty[s][k] = m_dirty[s][k-1];
            end
            if (wr) begin sd = d; sdy = 1'b1; end else m_rd = sd;
            m_tag[s][0] = st; m_data[s][0] = sd; m_dirty[s][0] = sdy;
            m_hits++;
        end else begin
            if (m_cnt[s] == NW) begin
                if (m_dirty[s][NW-1]) begin
                    exp_we.push_back(1'b1);
                    exp_ma.push_back({m_tag[s][NW-1], s});
                    exp_wd.push_back(m_data[s][NW-1]);
                end
                m_cnt[s] = NW - 1;
            end
            for (int k = m_cnt[s]; k > 0; k--) begin
                m_tag[s][k] = m_tag[s][k-1]; m_data[s][k] = m_data[s][k-1];
                m_dirty[s][k] = m_dirty[s][k-1];
            end
            m_tag[s][0] = t;
            if (wr) begin
                m_data[s][0] = d; m_dirty[s][0] = 1'b1;
            end else begin
                exp_we.push_back(1'b0); exp_ma.push_back(a); exp_wd.push_back('0);
                m_data[s][0] = a; m_dirty[s][0] = 1'b0; m_rd = a;
            end
            m_cnt[s]++;
            m_misses++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int n);
        return (n > MAXC) ? MAXC : n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; read = 1'b0; write = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One request from IDLE through its response, checked against the model.
    task automatic do_req(input bit wr, input bit rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        bit eh, got;
        int edges;
        exp_we.delete(); exp_ma.delete(); exp_wd.delete();
        log_we.delete(); log_ma.delete(); log_wd.delete();
        req_seen = 1'b0;
        model_access(wr, a, d, eh);
        @(negedge clk);
        addr = a; wdata = d; write = wr; read = rd;
        @(posedge clk);
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        edges = 1; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (resp_valid) begin got = 1'b1; break; end
            @(posedge clk); edges++;
            @(negedge clk);
        end
        check("resp_seen", got, 1);
        check("l1_hit", l1_hit, eh);
        check("miss", miss, !eh);
        check("read_data", read_data, m_rd);
        check("hit_count", hit_count, sat(m_hits));
        check("miss_count", miss_count, sat(m_misses));
        if (eh) begin
            check("hit_latency", edges, 2);
            check("hit_no_mem_req", req_seen, 0);
        end
        check("mem_txn_count", log_we.size(), exp_we.size());
        for (int i = 0; i < exp_we.size() && i < log_we.size(); i++) begin
            check("mem_we", log_we[i], exp_we[i]);
            check("mem_addr", log_ma[i], exp_ma[i]);
            if (exp_we[i]) check("mem_wdata", log_wd[i], exp_wd[i]);
        end
    endtask

    task automatic wait_mem_req(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_req) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check(tag, ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            got;
        logic [AW-1:0] ra;
        // Reset state.
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_l1_hit", l1_hit, 0);
        check("rst_miss", miss, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_read_data", read_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);

        // Scenario 1: cold miss then hit.
        do_req(0, 1, 11'h123, '0);
        check("s1_fill_data", read_data, 11'h123);
        do_req(0, 1, 11'h123, '0);
        check("s1_hit", l1_hit, 1);

        // Scenario 2: LRU eviction inside set 3.
        do_req(0, 1, 11'h003, '0);
        do_req(0, 1, 11'h00B, '0);
        do_req(0, 1, 11'h013, '0);
        do_req(0, 1, 11'h01B, '0);
        do_req(0, 1, 11'h003, '0);
        do_req(0, 1, 11'h023, '0);
        do_req(0, 1, 11'h00B, '0);
        check("s2_evicted_miss", miss, 1);
        do_req(0, 1, 11'h003, '0);
        check("s2_kept_hit", l1_hit, 1);
        check("s6_hits_after_s2", hit_count, 3);
        check("s6_misses_after_s2", miss_count, 7);

        // Scenario 3: dirty victim written back before the fill.
        do_reset();
        do_req(0, 1, 11'h003, '0);
        do_req(0, 1, 11'h00B, '0);
        do_req(0, 1, 11'h013, '0);
        do_req(0, 1, 11'h01B, '0);
        do_req(1, 0, 11'h013, 11'h7FF);
        check("s3_write_hit", l1_hit, 1);
        do_req(0, 1, 11'h023, '0);
        do_req(0, 1, 11'h02B, '0);
        do_req(0, 1, 11'h033, '0);
        do_req(0, 1, 11'h03B, '0);
        check("s3_wb_txns", log_we.size(), 2);
        check("s3_wb_we", (log_we.size() > 0) ? log_we[0] : 1'b0, 1);
        check("s3_wb_addr", (log_ma.size() > 0) ? log_ma[0] : '0, 11'h013);
        check("s3_wb_data", (log_wd.size() > 0) ? log_wd[0] : '0, 11'h7FF);

        // Scenario 4: write-allocate and write priority.
        do_req(1, 0, 11'h345, 11'h055);
        check("s4_alloc_no_mem", log_we.size(), 0);
        do_req(0, 1, 11'h345, '0);
        check("s4_read_back", read_data, 11'h055);
        do_req(1, 1, 11'h345, 11'h111);
        do_req(0, 1, 11'h345, '0);
        check("s4_write_prio", read_data, 11'h111);

        // Scenario 5: slow memory, ignored request while busy, reset mid-fill.
        do_reset();
        mem_delay = 5;
        log_we.delete(); log_ma.delete(); log_wd.delete();
        @(negedge clk);
        addr = 11'h200; read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        wait_mem_req("s5_fill_req");
        check("s5_busy_fill", busy, 1);
        addr = 11'h007; read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        check("s5_busy_after_pulse", busy, 1);
        check("s5_fill_addr", mem_addr, 11'h200);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (resp_valid) begin got = 1'b1; break; end
            check("s5_busy_wait", busy, 1);
            @(negedge clk);
        end
        check("s5_resp", got, 1);
        check("s5_read_data", read_data, 11'h200);
        repeat (3) begin
            @(negedge clk);
            check("s5_ignored_no_resp", resp_valid, 0);
            check("s5_ignored_idle", busy, 0);
        end
        check("s5_one_txn", log_we.size(), 1);
        @(negedge clk);
        addr = 11'h300; read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        wait_mem_req("s5_fill_req2");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("s5_rst_mem_req", mem_req, 0);
        check("s5_rst_busy", busy, 0);
        rst = 1'b0;
        model_reset();
        mem_delay = 1;
        do_req(0, 1, 11'h123, '0);
        check("s5_after_rst_miss", miss, 1);

        // Random traffic over a small address pool.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            bit wr, rd;
            mem_delay = $urandom_range(0, 3);
            ra = {TW'($urandom_range(0, 5)), IW'($urandom_range(0, NS - 1))};
            wr = $urandom_range(0, 1);
            rd = wr ? ($urandom_range(0, 7) == 0) : 1'b1;
            do_req(wr, rd, ra, DW'($urandom));
        end
        mem_delay = 1;

        // Scenario 6: hit counter saturation.
        do_reset();
        do_req(0, 1, 11'h123, '0);
        for (int n = 0; n < MAXC + 8; n++) do_req(0, 1, 11'h123, '0);
        check("s6_hit_sat", hit_count, MAXC);
        check("s6_miss_one", miss_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
